// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: FSM state encoding,
// direction constants and the direction-choice result record.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Outcome of the SCAN direction decision: where to go and the preferred direction.
  typedef struct packed {
    state_e state;
    logic   dir;
  } choice_t;

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Call/status bundle of the SCAN elevator controller. The master drives floor
// calls; the slave (controller) drives the registered floor index and flags.
interface elevator_scan_controller_if #(
  parameter int unsigned NUM_FLOORS = 8
);
  localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS);

  // req_in is a per-floor call with no backpressure: a 1-cycle pulse or a held
  // level both latch the call; every status signal below is a register output.
  logic [NUM_FLOORS-1:0]    req_in;
  logic [FLOOR_W-1:0]       current_floor;
  logic [NUM_FLOORS-1:0]    pending;
  logic                     moving_up;
  logic                     moving_down;
  logic                     door_open;
  logic                     idle;
  elevator_pkg::state_e     state_dbg;
  logic                     dir_dbg;

  modport master (
    output req_in,
    input  current_floor, pending, moving_up, moving_down, door_open, idle,
    input  state_dbg, dir_dbg
  );

  modport slave (
    input  req_in,
    output current_floor, pending, moving_up, moving_down, door_open, idle,
    output state_dbg, dir_dbg
  );

endinterface

// File: rtl/elevator_tick_timer.sv
// Free-running cycle counter with synchronous clear; done is high on the
// COUNT-th cycle after a clear and the counter wraps to zero on that edge.
module elevator_tick_timer #(
  parameter int unsigned COUNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done
);

  localparam int unsigned W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // done depends only on the register so clear may be derived from decisions that use done.
  assign done = (count_q == LAST);

  always_comb begin
    count_d = count_q + W'(1);
    if (clear || done) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator controller: latches floor calls, sweeps in one direction
// while calls remain ahead, then reverses. Door dwell: ELEVATOR_DOOR_DWELL_EN.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = 8,
  parameter int unsigned TICK_COUNT  = 10_000_000,
  parameter int unsigned DOOR_CYCLES = 30_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  elevator_scan_controller_if.slave   bus
);

  localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  if ((NUM_FLOORS < 2) || (NUM_FLOORS > 16)) begin : g_bad_floors
    $error("NUM_FLOORS must be in 2..16");
  end
  if (TICK_COUNT < 2) begin : g_bad_tick
    $error("TICK_COUNT must be at least 2");
  end
  if (DOOR_CYCLES < 1) begin : g_bad_door
    $error("DOOR_CYCLES must be at least 1");
  end

  state_e                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [FLOOR_W-1:0]     floor_q, floor_d;
  logic [NUM_FLOORS-1:0]  pending_q, pending_d;
  logic                   arrive_q, arrive_d;

  logic                   above, below;
  logic [NUM_FLOORS-1:0]  serve_mask;
  choice_t                pick;
  logic                   moving;
  logic                   travel_clear, travel_done;
  logic                   door_done;

  function automatic choice_t choose(input logic d, input logic a, input logic b);
    choice_t c;
    c.state = IDLE;
    c.dir   = d;
    if ((d == DIR_UP) && a) begin
      c.state = MOVE_UP;
    end else if ((d == DIR_DOWN) && b) begin
      c.state = MOVE_DOWN;
    end else if (a) begin
      c.state = MOVE_UP;
      c.dir   = DIR_UP;
    end else if (b) begin
      c.state = MOVE_DOWN;
      c.dir   = DIR_DOWN;
    end
    return c;
  endfunction

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (i > int'(floor_q))) above = 1'b1;
      if (pending_q[i] && (i < int'(floor_q))) below = 1'b1;
    end
  end

  assign moving = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);

  // Held at zero outside MOVE states; a reversal at an arrival also restarts it.
  assign travel_clear = !moving || (state_d != state_q);

  elevator_tick_timer #(
    .COUNT (TICK_COUNT)
  ) u_travel_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (travel_clear),
    .done  (travel_done)
  );

`ifdef ELEVATOR_DOOR_DWELL_EN
  logic restart;
  logic dwell_clear;
  logic dwell_done;

  // A new call for the open floor is absorbed and keeps the door open longer.
  assign restart     = (state_q == DOOR_OPEN) && bus.req_in[floor_q];
  assign dwell_clear = (state_q != DOOR_OPEN) || restart;

  elevator_tick_timer #(
    .COUNT (DOOR_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dwell_clear),
    .done  (dwell_done)
  );

  assign door_done = dwell_done && !restart;
`else
  assign door_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      arrive_q  <= arrive_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    arrive_d = 1'b0;
    pick     = choose(dir_q, above, below);

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = DOOR_OPEN;
        end else begin
          state_d = pick.state;
          dir_d   = pick.dir;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (arrive_q) begin
          if (pending_q[floor_q]) begin
            state_d = DOOR_OPEN;
          end else begin
            state_d = pick.state;
            dir_d   = pick.dir;
          end
        end else if (travel_done) begin
          arrive_d = 1'b1;
          if ((state_q == MOVE_UP) && (floor_q != TOP_FLOOR)) begin
            floor_d = floor_q + FLOOR_W'(1);
          end else if ((state_q == MOVE_DOWN) && (floor_q != '0)) begin
            floor_d = floor_q - FLOOR_W'(1);
          end
        end
      end
      DOOR_OPEN: begin
        if (door_done) begin
          state_d = pick.state;
          dir_d   = pick.dir;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    serve_mask = '0;
    if ((state_d == DOOR_OPEN) || (state_q == DOOR_OPEN)) begin
      serve_mask = NUM_FLOORS'(1) << floor_q;
    end
    pending_d = (pending_q | bus.req_in) & ~serve_mask;
  end

  always_comb begin
    bus.current_floor = floor_q;
    bus.pending       = pending_q;
    bus.moving_up     = (state_q == MOVE_UP);
    bus.moving_down   = (state_q == MOVE_DOWN);
    bus.door_open     = (state_q == DOOR_OPEN);
    bus.idle          = (state_q == IDLE);
    bus.state_dbg     = state_q;
    bus.dir_dbg       = dir_q;
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller (8 floors, 4-cycle travel,
// 3-cycle dwell); door length follows ELEVATOR_DOOR_DWELL_EN.
module tb_elevator_scan_controller;
  localparam int NF   = 8;
  localparam int TICK = 4;
  localparam int DOOR = 3;
`ifdef ELEVATOR_DOOR_DWELL_EN
  localparam int DOOR_LEN = DOOR;
`else
  localparam int DOOR_LEN = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];
  logic door_prev = 1'b0;

  elevator_scan_controller_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_controller #(
    .NUM_FLOORS  (NF),
    .TICK_COUNT  (TICK),
    .DOOR_CYCLES (DOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each door opening pops the floor it was expected at
  always @(negedge clk) begin
    if (bus.door_open && !door_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_door_floor", 32'(bus.current_floor), 32'hFFFF_FFFF);
      end else begin
        check("door_floor", 32'(bus.current_floor), exp_q.pop_front());
      end
    end
    door_prev = bus.door_open;
  end

  // driver tasks
  task automatic do_reset();
    bus.req_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [NF-1:0] m);
    bus.req_in = m;
    @(negedge clk);
    bus.req_in = '0;
  endtask

  task automatic wait_floor(input int f, input int budget, input string tag);
    int n = 0;
    while ((int'(bus.current_floor) != f) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.current_floor), 32'(f));
  endtask

  task automatic wait_door(input int budget, input string tag);
    int n = 0;
    while (!bus.door_open && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.door_open), 32'd1);
  endtask

  task automatic measure_door(output int len);
    len = 0;
    while (bus.door_open && (len < 64)) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int t0;
    int len;
    int seen_move;
    int door_cnt;

    bus.req_in = '0;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_floor",     32'(bus.current_floor), 32'd0);
    check("rst_pending",   32'(bus.pending),       32'd0);
    check("rst_idle",      32'(bus.idle),          32'd1);
    check("rst_up",        32'(bus.moving_up),     32'd0);
    check("rst_down",      32'(bus.moving_down),   32'd0);
    check("rst_door",      32'(bus.door_open),     32'd0);
    check("rst_dir",       32'(bus.dir_dbg),       32'd1);

    // scenario 1: single call at floor 5
    t0 = cyc;
    exp_q.push_back(32'd5);
    pulse_req(8'h20);
    check("s1_pending",  32'(bus.pending), 32'h20);
    check("s1_idle_lat", 32'(bus.idle),    32'd1);
    @(negedge clk);
    check("s1_move_up",  32'(bus.moving_up), 32'd1);
    wait_door(100, "s1_door");
    // 1 latch + 1 start + 5 floors * TICK + 1 arrival check
    check("s1_latency",  32'(cyc - t0), 32'(2 + 5 * TICK + 1));
    check("s1_pend_clr", 32'(bus.pending), 32'd0);
    measure_door(len);
    check("s1_door_len", 32'(len), 32'(DOOR_LEN));
    check("s1_idle_end", 32'(bus.idle), 32'd1);
    check("s1_floor_end", 32'(bus.current_floor), 32'd5);

    // scenario 2: call at the current floor opens the door from IDLE
    do_reset();
    exp_q.push_back(32'd0);
    pulse_req(8'h01);
    check("s2_pending", 32'(bus.pending), 32'h01);
    seen_move = 0;
    door_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.moving_up || bus.moving_down) seen_move++;
      if (bus.door_open) door_cnt++;
      @(negedge clk);
    end
    check("s2_no_move",  32'(seen_move), 32'd0);
    check("s2_door_len", 32'(door_cnt),  32'(DOOR_LEN));
    check("s2_floor",    32'(bus.current_floor), 32'd0);
    check("s2_idle",     32'(bus.idle), 32'd1);

    // scenario 3: SCAN order 4, 6 then reverse to 1
    do_reset();
    pulse_req(8'h40);
    wait_floor(3, 100, "s3_reach3");
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd1);
    pulse_req(8'h12);
    check("s3_pending", 32'(bus.pending), 32'h52);
    wait_door(100, "s3_door4");
    check("s3_at4", 32'(bus.current_floor), 32'd4);
    measure_door(len);
    check("s3_dir_up", 32'(bus.dir_dbg), 32'd1);
    wait_door(100, "s3_door6");
    measure_door(len);
    check("s3_rev_down", 32'(bus.moving_down), 32'd1);
    check("s3_dir_down", 32'(bus.dir_dbg),     32'd0);
    wait_door(100, "s3_door1");
    check("s3_at1", 32'(bus.current_floor), 32'd1);
    measure_door(len);
    check("s3_idle",    32'(bus.idle),    32'd1);
    check("s3_pending_end", 32'(bus.pending), 32'd0);

`ifdef ELEVATOR_DOOR_DWELL_EN
    // scenario 4: same-floor call while the door is open restarts the dwell
    do_reset();
    exp_q.push_back(32'd2);
    pulse_req(8'h04);
    wait_door(100, "s4_door2");
    @(negedge clk);
    pulse_req(8'h04);
    check("s4_pend_absorbed", 32'(bus.pending[2]), 32'd0);
    measure_door(len);
    check("s4_door_ext", 32'(len), 32'(DOOR));
    check("s4_idle", 32'(bus.idle), 32'd1);
`endif

    // scenario 5: asynchronous reset mid-travel
    do_reset();
    pulse_req(8'h80);
    wait_floor(3, 100, "s5_reach3");
    check("s5_pending", 32'(bus.pending), 32'h80);
    rst_n = 1'b0;
    #1;
    check("s5_rst_floor",   32'(bus.current_floor), 32'd0);
    check("s5_rst_pending", 32'(bus.pending),       32'd0);
    check("s5_rst_idle",    32'(bus.idle),          32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen_move = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.moving_up || bus.moving_down || bus.door_open) seen_move++;
    end
    check("s5_no_move", 32'(seen_move), 32'd0);
    check("s5_floor",   32'(bus.current_floor), 32'd0);

    // random single calls from a fresh reset: door opens at the called floor
    for (int k = 0; k < 3; k++) begin
      int f;
      f = $urandom_range(NF - 1, 1);
      do_reset();
      exp_q.push_back(32'(f));
      pulse_req(NF'(1) << f);
      wait_door(200, "rnd_door");
      measure_door(len);
      check("rnd_door_len", 32'(len), 32'(DOOR_LEN));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
